// File: rtl/vacc_cmd_scheduler.sv
// Round-robin scheduler sharing one read/write mover pair and the stream router.
// Optional perf counters are built when VACC_SCHED_PERF_EN is defined.
module vacc_cmd_scheduler #(
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 13,
  parameter int DEST_WIDTH = 3,
  parameter int N_REQ      = 2
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0]      req_src,
  input  logic [N_REQ*ADDR_WIDTH-1:0]      req_dst,
  input  logic [N_REQ*LEN_WIDTH-1:0]       req_len,
  input  logic [N_REQ*DEST_WIDTH-1:0]      req_route,
  output logic [N_REQ-1:0]                 done_valid,
  output logic                             busy,
  output logic [1:0]                       owner,
  output logic [DEST_WIDTH-1:0]            routing_dest,
  output logic [ADDR_WIDTH-1:0]            rd_src,
  output logic [LEN_WIDTH-1:0]             rd_len,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [ADDR_WIDTH-1:0]            wr_dest,
  output logic                             wr_valid,
  input  logic                             wr_ready
`ifdef VACC_SCHED_PERF_EN
  ,
  input  logic                             perf_clr,
  output logic [31:0]                      perf_busy_cycles,
  output logic [31:0]                      perf_cmds
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [LEN_WIDTH-1:0]  len;
    logic [DEST_WIDTH-1:0] route;
  } cmd_t;

  state_e     state_q, state_d;
  cmd_t       cmd_q, cmd_d, sel_cmd;
  logic       rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
  logic [1:0] owner_q, owner_d, last_grant_q, last_grant_d;
  logic       win_found, accept;
  logic [1:0] win_idx;
  int         cand;

  // Rotating priority: first valid requester after the last grant wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (!win_found && cand == i && req_valid[i]) begin
          win_found = 1'b1;
          win_idx   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == 2'(i)) begin
        sel_cmd.src   = req_src[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_cmd.dst   = req_dst[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_cmd.len   = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        sel_cmd.route = req_route[i*DEST_WIDTH +: DEST_WIDTH];
      end
    end
  end

  assign accept = (state_q == S_IDLE) && win_found;

  // Gated by reset so every output reads zero while reset is held.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = accept && !areset && (win_idx == 2'(i));
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    rd_valid_d   = rd_valid_q;
    wr_valid_d   = wr_valid_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d   = sel_cmd;
          owner_d = win_idx;
          if (sel_cmd.len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ISSUE;
            rd_valid_d = 1'b1;
            wr_valid_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;
        if (wr_valid_q && wr_ready) wr_valid_d = 1'b0;
        if (!rd_valid_d && !wr_valid_d) state_d = S_RUN;
      end
      S_RUN: begin
        if (rd_ready && wr_ready) state_d = S_DONE;
      end
      S_DONE: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      rd_valid_q   <= 1'b0;
      wr_valid_q   <= 1'b0;
      owner_q      <= '0;
      last_grant_q <= 2'(N_REQ - 1);
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      rd_valid_q   <= rd_valid_d;
      wr_valid_q   <= wr_valid_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    done_valid = '0;
    for (int i = 0; i < N_REQ; i++)
      done_valid[i] = (state_q == S_DONE) && (owner_q == 2'(i));
  end

  assign busy         = (state_q != S_IDLE);
  assign owner        = owner_q;
  assign routing_dest = cmd_q.route;
  assign rd_src       = cmd_q.src;
  assign rd_len       = cmd_q.len;
  assign wr_dest      = cmd_q.dst;
  assign rd_valid     = rd_valid_q;
  assign wr_valid     = wr_valid_q;

`ifdef VACC_SCHED_PERF_EN
  logic [31:0] perf_busy_q, perf_cmds_q;

  // Clear wins over increment; busy count saturates instead of wrapping.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      perf_busy_q <= '0;
      perf_cmds_q <= '0;
    end else begin
      if (perf_clr) perf_busy_q <= '0;
      else if (busy && perf_busy_q != '1) perf_busy_q <= perf_busy_q + 32'd1;
      if (perf_clr) perf_cmds_q <= '0;
      else if (state_q == S_DONE) perf_cmds_q <= perf_cmds_q + 32'd1;
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_cmds        = perf_cmds_q;
`endif

endmodule

// File: tb/tb_vacc_cmd_scheduler.sv
// Directed bench for vacc_cmd_scheduler with a latency-programmable mover model.
module tb_vacc_cmd_scheduler;
  localparam int AW = 64, LW = 13, DW = 3, NR = 2;

  logic            aclk = 1'b0, areset = 1'b0;
  logic [NR-1:0]   req_valid = '0, req_ready, done_valid;
  logic [NR*AW-1:0] req_src = '0, req_dst = '0;
  logic [NR*LW-1:0] req_len = '0;
  logic [NR*DW-1:0] req_route = '0;
  logic            busy, rd_valid, rd_ready, wr_valid, wr_ready;
  logic [1:0]      owner;
  logic [DW-1:0]   routing_dest;
  logic [AW-1:0]   rd_src, wr_dest;
  logic [LW-1:0]   rd_len;
  logic            wr_stall = 1'b0;
  int              rd_lat = 1, wr_lat = 1, rd_busy = 0, wr_busy = 0;
  int              n_checks = 0, n_fail = 0;
`ifdef VACC_SCHED_PERF_EN
  logic            perf_clr = 1'b0;
  logic [31:0]     perf_busy_cycles, perf_cmds;
  int              busy_acc = 0;
`endif

  vacc_cmd_scheduler #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DEST_WIDTH(DW), .N_REQ(NR)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_len(req_len), .req_route(req_route),
    .done_valid(done_valid), .busy(busy), .owner(owner), .routing_dest(routing_dest),
    .rd_src(rd_src), .rd_len(rd_len), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_dest(wr_dest), .wr_valid(wr_valid), .wr_ready(wr_ready)
`ifdef VACC_SCHED_PERF_EN
    , .perf_clr(perf_clr), .perf_busy_cycles(perf_busy_cycles), .perf_cmds(perf_cmds)
`endif
  );

  always #5 aclk = ~aclk;

  // Mover model: ready drops after a handshake and returns after *_lat cycles.
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_busy <= 0;
      wr_busy <= 0;
    end else begin
      if (rd_valid && rd_ready) rd_busy <= rd_lat;
      else if (rd_busy != 0)    rd_busy <= rd_busy - 1;
      if (wr_valid && wr_ready) wr_busy <= wr_lat;
      else if (wr_busy != 0)    wr_busy <= wr_busy - 1;
    end
  end
  assign rd_ready = (rd_busy == 0);
  assign wr_ready = (wr_busy == 0) && !wr_stall;

  task automatic set_cmd(input int i, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [LW-1:0] l, input logic [DW-1:0] r);
    req_src[i*AW +: AW]   = s;
    req_dst[i*AW +: AW]   = d;
    req_len[i*LW +: LW]   = l;
    req_route[i*DW +: DW] = r;
  endtask

  task automatic test_reset();
    #1 areset = 1'b1;
    repeat (2) @(negedge aclk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if ({rd_valid, wr_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_valids: got %b want 00", {rd_valid, wr_valid}); end
    n_checks++; if ({rd_src, wr_dest, rd_len, routing_dest} !== '0) begin n_fail++; $display("FAIL rst_cmd: got src %h dst %h len %h rt %h want 0", rd_src, wr_dest, rd_len, routing_dest); end
    n_checks++; if ({owner, done_valid, req_ready} !== '0) begin n_fail++; $display("FAIL rst_ctl: got owner %0d done %b rdy %b want 0", owner, done_valid, req_ready); end
    areset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_rdy_idle: got %b want 00", req_ready); end
  endtask

  task automatic test_fairness();
    int grants[4], dones[4], ng, nd, c;
    grants = '{-1, -1, -1, -1};
    dones  = '{-1, -1, -1, -1};
    ng = 0; nd = 0; c = 0;
    @(negedge aclk); areset = 1'b1;
    @(negedge aclk); areset = 1'b0;
    set_cmd(0, 64'h100, 64'h200, 13'h40, 3'd2);
    set_cmd(1, 64'h300, 64'h400, 13'h40, 3'd3);
    req_valid = 2'b11;
    while (nd < 4 && c < 100) begin
      #1;
      if (req_ready != 2'b00 && ng < 4) begin grants[ng] = (req_ready == 2'b10) ? 1 : 0; ng++; end
      if (done_valid != 2'b00 && nd < 4) begin dones[nd] = (done_valid == 2'b10) ? 1 : 0; nd++; end
      if (nd < 4) begin @(negedge aclk); c++; end
    end
    req_valid = 2'b00;
    n_checks++; if (nd != 4) begin n_fail++; $display("FAIL fair_timeout: got %0d done pulses want 4", nd); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (grants[i] != i % 2) begin n_fail++; $display("FAIL fair_grant%0d: got %0d want %0d", i, grants[i], i % 2); end
      n_checks++; if (dones[i] != i % 2) begin n_fail++; $display("FAIL fair_done%0d: got %0d want %0d", i, dones[i], i % 2); end
    end
  endtask

  task automatic test_single();
    @(negedge aclk);
    set_cmd(0, 64'h1000, 64'h2000, 13'h40, 3'd1);
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_rdy: got %b want 01", req_ready); end
    @(negedge aclk);
    n_checks++; if ({rd_valid, wr_valid} !== 2'b11) begin n_fail++; $display("FAIL single_issue: got %b want 11", {rd_valid, wr_valid}); end
    n_checks++; if (rd_src !== 64'h1000 || rd_len !== 13'h40) begin n_fail++; $display("FAIL single_rd: got %h/%h want 1000/40", rd_src, rd_len); end
    n_checks++; if (wr_dest !== 64'h2000 || routing_dest !== 3'd1) begin n_fail++; $display("FAIL single_wr: got %h/%0d want 2000/1", wr_dest, routing_dest); end
    n_checks++; if (req_ready !== 2'b00 || busy !== 1'b1 || owner !== 2'd0) begin n_fail++; $display("FAIL single_ctl: got rdy %b busy %b owner %0d want 00 1 0", req_ready, busy, owner); end
    req_valid = 2'b00;
    @(negedge aclk);
    n_checks++; if ({rd_valid, wr_valid, done_valid} !== 4'b0) begin n_fail++; $display("FAIL single_run: got %b want 0000", {rd_valid, wr_valid, done_valid}); end
    @(negedge aclk);
    n_checks++; if (done_valid !== 2'b00) begin n_fail++; $display("FAIL single_early: got %b want 00", done_valid); end
    @(negedge aclk);
    n_checks++; if (done_valid !== 2'b01) begin n_fail++; $display("FAIL single_done: got %b want 01", done_valid); end
    @(negedge aclk);
    n_checks++; if (done_valid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got done %b busy %b want 00 0", done_valid, busy); end
    n_checks++; if (rd_src !== 64'h1000 || routing_dest !== 3'd1) begin n_fail++; $display("FAIL single_hold: got %h/%0d want 1000/1", rd_src, routing_dest); end
  endtask

  task automatic test_len_zero();
    int busy_n; logic saw;
    busy_n = 0; saw = 1'b0;
    @(negedge aclk);
    set_cmd(1, 64'h500, 64'h600, 13'h0, 3'd5);
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL len0_rdy: got %b want 10", req_ready); end
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      if (c == 0) begin
        n_checks++; if (done_valid !== 2'b10) begin n_fail++; $display("FAIL len0_done: got %b want 10", done_valid); end
        n_checks++; if (routing_dest !== 3'd5 || rd_len !== 13'h0) begin n_fail++; $display("FAIL len0_cmd: got %0d/%h want 5/0", routing_dest, rd_len); end
        req_valid = 2'b00;
      end
      if (c == 1) begin
        n_checks++; if (done_valid !== 2'b00) begin n_fail++; $display("FAIL len0_pulse: got %b want 00", done_valid); end
      end
      busy_n += busy ? 1 : 0;
      saw = saw | rd_valid | wr_valid;
    end
    n_checks++; if (busy_n != 1) begin n_fail++; $display("FAIL len0_busy: got %0d cycles want 1", busy_n); end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL len0_valid: got %b want 0", saw); end
  endtask

  task automatic test_wr_stall();
    @(negedge aclk);
    set_cmd(0, 64'h700, 64'h800, 13'h80, 3'd4);
    wr_stall  = 1'b1;
    req_valid = 2'b01;
    @(negedge aclk);
    n_checks++; if ({rd_valid, wr_valid} !== 2'b11) begin n_fail++; $display("FAIL stall_issue: got %b want 11", {rd_valid, wr_valid}); end
    req_valid = 2'b00;
    @(negedge aclk);
    n_checks++; if ({rd_valid, wr_valid} !== 2'b01) begin n_fail++; $display("FAIL stall_rd_drop: got %b want 01", {rd_valid, wr_valid}); end
    for (int k = 3; k <= 6; k++) begin
      @(negedge aclk);
      n_checks++; if ({wr_valid, done_valid} !== 3'b100) begin n_fail++; $display("FAIL stall_hold%0d: got %b want 100", k, {wr_valid, done_valid}); end
    end
    wr_stall = 1'b0;
    @(negedge aclk);
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_wr_drop: got %b want 0", wr_valid); end
    @(negedge aclk);
    n_checks++; if (done_valid !== 2'b00) begin n_fail++; $display("FAIL stall_early: got %b want 00", done_valid); end
    @(negedge aclk);
    n_checks++; if (done_valid !== 2'b01) begin n_fail++; $display("FAIL stall_done: got %b want 01", done_valid); end
    @(negedge aclk);
  endtask

  task automatic test_reset_mid();
    int c;
    rd_lat = 10; wr_lat = 10;
    @(negedge aclk);
    set_cmd(1, 64'h900, 64'hA00, 13'h40, 3'd6);
    req_valid = 2'b10;
    @(negedge aclk);
    req_valid = 2'b00;
    @(negedge aclk);
    n_checks++; if (busy !== 1'b1 || rd_src !== 64'h900) begin n_fail++; $display("FAIL mid_run: got busy %b src %h want 1 900", busy, rd_src); end
    areset = 1'b1;
    #1;
    n_checks++; if ({busy, rd_valid, wr_valid, owner, done_valid} !== '0) begin n_fail++; $display("FAIL mid_ctl: got %b want 0", {busy, rd_valid, wr_valid, owner, done_valid}); end
    n_checks++; if ({rd_src, wr_dest, rd_len, routing_dest} !== '0) begin n_fail++; $display("FAIL mid_cmd: got src %h dst %h want 0", rd_src, wr_dest); end
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_rdy: got %b want 00", req_ready); end
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      n_checks++; if (done_valid !== 2'b00) begin n_fail++; $display("FAIL mid_nodone%0d: got %b want 00", k, done_valid); end
    end
    areset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_regrant: got %b want 01", req_ready); end
    @(negedge aclk);
    n_checks++; if (owner !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_owner: got %0d busy %b want 0 1", owner, busy); end
    req_valid = 2'b00;
    c = 0;
    while (busy && c < 60) begin @(negedge aclk); c++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_drain: got busy %b want 0", busy); end
    rd_lat = 1; wr_lat = 1;
  endtask

`ifdef VACC_SCHED_PERF_EN
  task automatic run_cmd(input int i, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [LW-1:0] l, input logic [DW-1:0] r);
    int c; bit got;
    c = 0; got = 1'b0;
    set_cmd(i, s, d, l, r);
    req_valid = '0;
    req_valid[i] = 1'b1;
    busy_acc += busy ? 1 : 0;
    while (!got && c < 100) begin
      @(negedge aclk); c++;
      busy_acc += busy ? 1 : 0;
      if (busy) req_valid = '0;
      if (done_valid[i]) got = 1'b1;
    end
    if (!got) begin n_checks++; n_fail++; $display("FAIL run_cmd_timeout: req %0d got no done pulse", i); end
    @(negedge aclk);
    busy_acc += busy ? 1 : 0;
  endtask

  task automatic test_perf();
    rd_lat = 10; wr_lat = 10;
    @(negedge aclk); perf_clr = 1'b1;
    @(negedge aclk); perf_clr = 1'b0;
    n_checks++; if (perf_busy_cycles !== 32'd0 || perf_cmds !== 32'd0) begin n_fail++; $display("FAIL perf_clr0: got %0d/%0d want 0/0", perf_busy_cycles, perf_cmds); end
    busy_acc = 0;
    run_cmd(0, 64'hB00, 64'hC00, 13'h40, 3'd1);
    run_cmd(1, 64'hD00, 64'hE00, 13'h40, 3'd2);
    n_checks++; if (perf_cmds !== 32'd2) begin n_fail++; $display("FAIL perf_cmds: got %0d want 2", perf_cmds); end
    n_checks++; if (perf_busy_cycles !== 32'(busy_acc)) begin n_fail++; $display("FAIL perf_busy: got %0d want %0d", perf_busy_cycles, busy_acc); end
    n_checks++; if (busy_acc != 26) begin n_fail++; $display("FAIL perf_busy_total: got %0d want 26", busy_acc); end
    perf_clr = 1'b1;
    @(negedge aclk);
    n_checks++; if (perf_busy_cycles !== 32'd0 || perf_cmds !== 32'd0) begin n_fail++; $display("FAIL perf_clr1: got %0d/%0d want 0/0", perf_busy_cycles, perf_cmds); end
    perf_clr = 1'b0;
    rd_lat = 1; wr_lat = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_len_zero();
    test_wr_stall();
    test_reset_mid();
`ifdef VACC_SCHED_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
